// File: rtl/p_flag_sequencer.sv
// Status-flag load sequencer: decodes flag-affecting opcodes at fetch and issues
// registered one-cycle load strobes to the status register after the class latency.
module p_flag_sequencer (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_sync,
  input  logic [7:0] i_ir,
  input  logic       i_rdy,
  output logic       o_acr_c,
  output logic       o_ir5_c,
  output logic       o_ir5_i,
  output logic       o_ir5_d,
  output logic       o_avr_v,
  output logic       o_clr_v,
  output logic       o_dbz_z,
  output logic       o_db7_n,
  output logic       o_busy,
  output logic       o_illegal
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;

  localparam logic [2:0] CL_NONE  = 3'd0;
  localparam logic [2:0] CL_FLAG  = 3'd1;
  localparam logic [2:0] CL_LDIMM = 3'd2;
  localparam logic [2:0] CL_ARIMM = 3'd3;
  localparam logic [2:0] CL_CPIMM = 3'd4;
  localparam logic [2:0] CL_LDZP  = 3'd5;

  // Strobe vector bit positions
  localparam int SB_ACR_C = 7;
  localparam int SB_IR5_C = 6;
  localparam int SB_IR5_I = 5;
  localparam int SB_IR5_D = 4;
  localparam int SB_AVR_V = 3;
  localparam int SB_CLR_V = 2;
  localparam int SB_DBZ_Z = 1;
  localparam int SB_DB7_N = 0;

  function automatic logic [2:0] decode_class(input logic [7:0] ir);
    logic [2:0] cl;
    case (ir)
      8'h18, 8'h38, 8'h58, 8'h78, 8'hD8, 8'hF8, 8'hB8: cl = CL_FLAG;
      8'hA9, 8'hA2, 8'hA0:                             cl = CL_LDIMM;
      8'h69, 8'hE9:                                    cl = CL_ARIMM;
      8'hC9, 8'hE0, 8'hC0:                             cl = CL_CPIMM;
      8'hA5, 8'hA6, 8'hA4:                             cl = CL_LDZP;
      default:                                         cl = CL_NONE;
    endcase
    return cl;
  endfunction

  // Posedges from the sync edge until the strobe is visible on the outputs
  function automatic logic [1:0] class_latency(input logic [2:0] cl);
    logic [1:0] lat;
    case (cl)
      CL_LDIMM, CL_ARIMM, CL_CPIMM: lat = 2'd2;
      CL_LDZP:                      lat = 2'd3;
      default:                      lat = 2'd1;
    endcase
    return lat;
  endfunction

  function automatic logic [7:0] class_strobes(input logic [2:0] cl, input logic [7:0] ir);
    logic [7:0] s;
    s = 8'h00;
    case (cl)
      CL_FLAG: begin
        case (ir)
          8'h18, 8'h38: s[SB_IR5_C] = 1'b1;
          8'h58, 8'h78: s[SB_IR5_I] = 1'b1;
          8'hD8, 8'hF8: s[SB_IR5_D] = 1'b1;
          8'hB8:        s[SB_CLR_V] = 1'b1;
          default:      s = 8'h00;
        endcase
      end
      CL_LDIMM, CL_LDZP: begin
        s[SB_DBZ_Z] = 1'b1;
        s[SB_DB7_N] = 1'b1;
      end
      CL_ARIMM: begin
        s[SB_ACR_C] = 1'b1;
        s[SB_AVR_V] = 1'b1;
        s[SB_DBZ_Z] = 1'b1;
        s[SB_DB7_N] = 1'b1;
      end
      CL_CPIMM: begin
        s[SB_ACR_C] = 1'b1;
        s[SB_DBZ_Z] = 1'b1;
        s[SB_DB7_N] = 1'b1;
      end
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] op_q, op_d;
  logic [2:0] cls_q, cls_d;
  logic [7:0] strobe_q, strobe_d;
  logic       busy_q, busy_d;
  logic       illegal_q, illegal_d;

  logic       start;
  logic [2:0] new_cls;
  logic [1:0] new_lat;

  assign start   = i_sync & i_rdy;
  assign new_cls = decode_class(i_ir);
  assign new_lat = class_latency(new_cls);

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    cls_d     = cls_q;
    strobe_d  = 8'h00;
    busy_d    = (state_q != ST_IDLE);
    illegal_d = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (i_rdy) begin
          if (cnt_q <= 2'd1) begin
            cnt_d   = 2'd0;
            state_d = ST_FIRE;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      ST_FIRE: begin
        if (i_rdy) begin
          strobe_d = class_strobes(cls_q, op_q);
          state_d  = ST_IDLE;
        end
      end
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new fetch overrides whatever is pending in WAIT and follows a FIRE cycle
    if (start) begin
      if (new_cls != CL_NONE) begin
        op_d    = i_ir;
        cls_d   = new_cls;
        cnt_d   = new_lat - 2'd1;
        state_d = (new_lat == 2'd1) ? ST_FIRE : ST_WAIT;
      end else begin
        illegal_d = 1'b1;
        cnt_d     = 2'd0;
        state_d   = ST_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      op_q      <= 8'h00;
      cls_q     <= CL_NONE;
      strobe_q  <= 8'h00;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      cls_q     <= cls_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_acr_c   = strobe_q[SB_ACR_C];
  assign o_ir5_c   = strobe_q[SB_IR5_C];
  assign o_ir5_i   = strobe_q[SB_IR5_I];
  assign o_ir5_d   = strobe_q[SB_IR5_D];
  assign o_avr_v   = strobe_q[SB_AVR_V];
  assign o_clr_v   = strobe_q[SB_CLR_V];
  assign o_dbz_z   = strobe_q[SB_DBZ_Z];
  assign o_db7_n   = strobe_q[SB_DB7_N];
  assign o_busy    = busy_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_p_flag_sequencer.sv
// Directed bench for p_flag_sequencer: a per-cycle vector table plus hand-written
// reset-abort sequences. Outputs are packed {strobes[7:0], busy, illegal}.
module tb_p_flag_sequencer;

  logic       clk;
  logic       reset_n;
  logic       sync;
  logic [7:0] ir;
  logic       rdy;
  logic       acr_c, ir5_c, ir5_i, ir5_d, avr_v, clr_v, dbz_z, db7_n, busy, illegal;

  int n_checks = 0;
  int n_errors = 0;

  p_flag_sequencer dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_sync    (sync),
    .i_ir      (ir),
    .i_rdy     (rdy),
    .o_acr_c   (acr_c),
    .o_ir5_c   (ir5_c),
    .o_ir5_i   (ir5_i),
    .o_ir5_d   (ir5_d),
    .o_avr_v   (avr_v),
    .o_clr_v   (clr_v),
    .o_dbz_z   (dbz_z),
    .o_db7_n   (db7_n),
    .o_busy    (busy),
    .o_illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe masks in {acr_c, ir5_c, ir5_i, ir5_d, avr_v, clr_v, dbz_z, db7_n} order
  localparam logic [7:0] M_C  = 8'h40;
  localparam logic [7:0] M_I  = 8'h20;
  localparam logic [7:0] M_D  = 8'h10;
  localparam logic [7:0] M_CV = 8'h04;
  localparam logic [7:0] M_ZN = 8'h03;
  localparam logic [7:0] M_AR = 8'h8B;
  localparam logic [7:0] M_CP = 8'h83;

  typedef struct {
    string      name;
    logic       sync;
    logic       rdy;
    logic [7:0] ir;
    logic [7:0] exp_strb;
    logic       exp_busy;
    logic       exp_ill;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] observed();
    return {acr_c, ir5_c, ir5_i, ir5_d, avr_v, clr_v, dbz_z, db7_n, busy, illegal};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got strb=%h busy=%b ill=%b, want strb=%h busy=%b ill=%b",
               name, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input string name, input logic s, input logic r, input logic [7:0] op,
                     input logic [7:0] strb, input logic b, input logic il);
    vec_t v;
    v.name = name; v.sync = s; v.rdy = r; v.ir = op;
    v.exp_strb = strb; v.exp_busy = b; v.exp_ill = il;
    vecs.push_back(v);
  endtask

  // Drive at negedge, sample 1 time unit after the following posedge
  task automatic step(input logic s, input logic r, input logic [7:0] op);
    @(negedge clk);
    sync = s; rdy = r; ir = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b1; sync = 1'b0; rdy = 1'b1; ir = 8'h00;

    // Each row: inputs applied before a posedge, outputs expected just after it
    add("sec_sync",   1, 1, 8'h38, 8'h00, 0, 0);
    add("sec_fire",   0, 1, 8'h00, M_C,   1, 0);
    add("sec_done",   0, 1, 8'h00, 8'h00, 0, 0);
    add("adc_sync",   1, 1, 8'h69, 8'h00, 0, 0);
    add("adc_p1",     0, 1, 8'h00, 8'h00, 1, 0);
    add("adc_p2",     0, 1, 8'h00, M_AR,  1, 0);
    add("adc_p3",     0, 1, 8'h00, 8'h00, 0, 0);
    add("ill_sync",   1, 1, 8'hEA, 8'h00, 0, 1);
    add("ill_after",  0, 1, 8'h00, 8'h00, 0, 0);
    add("lzp_sync",   1, 1, 8'hA5, 8'h00, 0, 0);
    add("lzp_stall1", 0, 0, 8'h00, 8'h00, 1, 0);
    add("lzp_stall2", 0, 0, 8'h00, 8'h00, 1, 0);
    add("lzp_p3",     0, 1, 8'h00, 8'h00, 1, 0);
    add("lzp_p4",     0, 1, 8'h00, 8'h00, 1, 0);
    add("lzp_p5",     0, 1, 8'h00, M_ZN,  1, 0);
    add("lzp_done",   0, 1, 8'h00, 8'h00, 0, 0);
    add("sync_nrdy",  1, 0, 8'h38, 8'h00, 0, 0);
    add("nrdy_after", 0, 1, 8'h00, 8'h00, 0, 0);
    add("abort_a5",   1, 1, 8'hA5, 8'h00, 0, 0);
    add("abort_18",   1, 1, 8'h18, 8'h00, 1, 0);
    add("abort_fire", 0, 1, 8'h00, M_C,   1, 0);
    add("abort_p3",   0, 1, 8'h00, 8'h00, 0, 0);
    add("abort_p4",   0, 1, 8'h00, 8'h00, 0, 0);
    add("cli_sync",   1, 1, 8'h58, 8'h00, 0, 0);
    add("cli_hold",   0, 0, 8'h00, 8'h00, 1, 0);
    add("cli_fire",   0, 1, 8'h00, M_I,   1, 0);
    add("cli_done",   0, 1, 8'h00, 8'h00, 0, 0);
    add("cld_sync",   1, 1, 8'hD8, 8'h00, 0, 0);
    add("clv_b2b",    1, 1, 8'hB8, M_D,   1, 0);
    add("clv_fire",   0, 1, 8'h00, M_CV,  1, 0);
    add("clv_done",   0, 1, 8'h00, 8'h00, 0, 0);
    add("cpy_sync",   1, 1, 8'hC0, 8'h00, 0, 0);
    add("cpy_p1",     0, 1, 8'h00, 8'h00, 1, 0);
    add("cpy_p2",     0, 1, 8'h00, M_CP,  1, 0);
    add("lda_sync",   1, 1, 8'hA9, 8'h00, 0, 0);
    add("lda_p1",     0, 1, 8'h00, 8'h00, 1, 0);
    add("lda_p2",     0, 1, 8'h00, M_ZN,  1, 0);
    add("lda_done",   0, 1, 8'h00, 8'h00, 0, 0);
    add("ldx_sync",   1, 1, 8'hA6, 8'h00, 0, 0);
    add("ill_in_wait",1, 1, 8'h00, 8'h00, 1, 1);
    add("ldx_gone1",  0, 1, 8'h00, 8'h00, 0, 0);
    add("ldx_gone2",  0, 1, 8'h00, 8'h00, 0, 0);

    #2 reset_n = 1'b0;
    #1 check("reset_state", observed(), 10'h000);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].sync, vecs[i].rdy, vecs[i].ir);
      check(vecs[i].name, observed(), {vecs[i].exp_strb, vecs[i].exp_busy, vecs[i].exp_ill});
    end

    // Reset while C9 sits in FIRE; release with a fresh sync pending
    step(1, 1, 8'hC9);
    check("c9_sync", observed(), 10'h000);
    step(0, 1, 8'h00);
    check("c9_wait", observed(), 10'h002);
    @(negedge clk);
    reset_n = 1'b0;
    #1 check("c9_rst_async", observed(), 10'h000);
    #2;
    reset_n = 1'b1; sync = 1'b1; ir = 8'h38; rdy = 1'b1;
    @(posedge clk);
    #1 check("post_rst_sync", observed(), 10'h000);
    step(0, 1, 8'h00);
    check("post_rst_fire", observed(), {M_C, 2'b10});
    step(0, 1, 8'h00);
    check("post_rst_done", observed(), 10'h000);

    // Reset while A4 waits; nothing may fire afterwards
    step(1, 1, 8'hA4);
    check("a4_sync", observed(), 10'h000);
    @(negedge clk);
    sync = 1'b0;
    reset_n = 1'b0;
    #1 check("a4_rst_async", observed(), 10'h000);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 8'h00);
      check("a4_no_strobe", observed(), 10'h000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
